// File: rtl/quad_decoder.sv
// quad_decoder: quadrature A/B decoder with 2-FF synchronisers, per-channel
// glitch filter, warm-up blanking after reset, sticky illegal-transition flag
// and an N-bit wrapping position counter.
// Optional feature macro: QUAD_INDEX_EN. When it is defined, a filtered rising
// edge of the index input zeroes the position while the filtered A/B is 11.
// When it is undefined, i_index is ignored.
module quad_decoder #(
  parameter int N    = 16,
  parameter int FILT = 2
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_quad_a,
  input  logic         i_quad_b,
  input  logic         i_clr,
  input  logic         i_err_clr,
  input  logic         i_index,
  output logic [N-1:0] o_pos,
  output logic         o_dir,
  output logic         o_step,
  output logic         o_err
);

  // Channel 0 is A and channel 1 is B. Channel 2 is index, present only with the feature.
`ifdef QUAD_INDEX_EN
  localparam int NCH = 3;
  logic [NCH-1:0] w_raw;
  assign w_raw = {i_index, i_quad_b, i_quad_a};
`else
  localparam int NCH = 2;
  logic [NCH-1:0] w_raw;
  logic           w_unusedIndex;
  assign w_raw         = {i_quad_b, i_quad_a};
  assign w_unusedIndex = i_index;
`endif

  localparam int CW   = (FILT > 1) ? $clog2(FILT + 1) : 1;
  localparam int WARM = FILT + 2;
  localparam int WW   = $clog2(WARM + 1);

  typedef enum logic {
    ST_WARM,
    ST_RUN
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [WW-1:0]   r_warmCnt;
  logic            w_warm;

  logic [NCH-1:0]  r_sync1;
  logic [NCH-1:0]  r_sync2;
  logic [NCH-1:0]  r_filt;
  logic [NCH-1:0]  r_prev;
  logic [CW-1:0]   r_filtCnt [NCH];

  logic [1:0]      w_curAB;
  logic [1:0]      w_prevAB;
  logic            w_fwd;
  logic            w_rev;
  logic            w_illegal;
  logic            w_idxLoad;

  logic [N-1:0]    r_pos;
  logic            r_dir;
  logic            r_step;
  logic            r_err;

  // Warm-up state register; the decoder stays blanked until the pipeline has filled.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_WARM;
      r_warmCnt <= '0;
    end else begin
      r_state <= w_nextState;
      if (r_state == ST_WARM) begin
        r_warmCnt <= r_warmCnt + WW'(1);
      end
    end
  end

  // Leave warm-up after exactly FILT+2 cycles out of reset.
  always_comb begin
    w_nextState = r_state;
    if (r_state == ST_WARM && r_warmCnt == WW'(WARM - 1)) begin
      w_nextState = ST_RUN;
    end
  end

  assign w_warm = (r_state == ST_WARM);

  // Two-flop synchroniser on every asynchronous encoder line.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Glitch filter: a new level is accepted only after FILT consecutive disagreeing samples.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_filt <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_filtCnt[i] <= '0;
      end
    end else if (w_warm) begin
      r_filt <= r_sync2;
      for (int i = 0; i < NCH; i++) begin
        r_filtCnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_filtCnt[i] <= '0;
        end else if (r_filtCnt[i] == CW'(FILT - 1)) begin
          r_filt[i]    <= r_sync2[i];
          r_filtCnt[i] <= '0;
        end else begin
          r_filtCnt[i] <= r_filtCnt[i] + CW'(1);
        end
      end
    end
  end

  // Previous filtered levels. During warm-up this follows the same value the
  // filter takes, so no spurious edge appears when warm-up ends.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_prev <= '0;
    end else if (w_warm) begin
      r_prev <= r_sync2;
    end else begin
      r_prev <= r_filt;
    end
  end

  assign w_curAB  = {r_filt[0], r_filt[1]};
  assign w_prevAB = {r_prev[0], r_prev[1]};

  // Classify the filtered {A,B} transition as forward, reverse or illegal.
  always_comb begin
    w_fwd     = 1'b0;
    w_rev     = 1'b0;
    w_illegal = 1'b0;
    case ({w_prevAB, w_curAB})
      4'b0010, 4'b1011, 4'b1101, 4'b0100: w_fwd     = 1'b1;
      4'b0001, 4'b0111, 4'b1110, 4'b1000: w_rev     = 1'b1;
      4'b0011, 4'b1100, 4'b0110, 4'b1001: w_illegal = 1'b1;
      default: ;
    endcase
    if (w_warm) begin
      w_fwd     = 1'b0;
      w_rev     = 1'b0;
      w_illegal = 1'b0;
    end
  end

`ifdef QUAD_INDEX_EN
  assign w_idxLoad = r_filt[2] & ~r_prev[2] & ~w_warm & (w_curAB == 2'b11);
`else
  assign w_idxLoad = 1'b0;
`endif

  // Step, direction and position. Clear beats index, and index beats a step.
  // The position wraps modulo 2^N.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pos  <= '0;
      r_dir  <= 1'b0;
      r_step <= 1'b0;
    end else begin
      r_step <= w_fwd | w_rev;
      if (w_fwd | w_rev) begin
        r_dir <= w_fwd;
      end
      if (i_clr) begin
        r_pos <= '0;
      end else if (w_idxLoad) begin
        r_pos <= '0;
      end else if (w_fwd) begin
        r_pos <= r_pos + N'(1);
      end else if (w_rev) begin
        r_pos <= r_pos - N'(1);
      end
    end
  end

  // Sticky illegal-transition flag; a new illegal edge wins over a coincident clear.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_err <= 1'b0;
    end else if (w_illegal) begin
      r_err <= 1'b1;
    end else if (i_err_clr) begin
      r_err <= 1'b0;
    end
  end

  assign o_pos  = r_pos;
  assign o_dir  = r_dir;
  assign o_step = r_step;
  assign o_err  = r_err;

endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: directed test of quad_decoder. Each issued encoder edge
// pushes its expected position, direction and arrival cycle into a queue; an
// independent monitor pops and compares whenever the DUT pulses step.
// Uses N=8 so the positive/negative wrap boundary is reachable quickly.
module tb_quad_decoder;

  localparam int BN    = 8;
  localparam int BFILT = 2;
  localparam int HOLD  = 10;

  typedef struct packed {
    logic [BN-1:0] pos;
    logic          dir;
    int            cyc;
  } sbEntry_t;

  logic          clk;
  logic          reset;
  logic          quadA;
  logic          quadB;
  logic          clr;
  logic          errClr;
  logic          index;
  logic [BN-1:0] pos;
  logic          dir;
  logic          step;
  logic          err;

  int            checks;
  int            errors;
  int            cycleCount;
  int            stepsSeen;
  int            stepsBefore;
  sbEntry_t      sbQ[$];
  logic [1:0]    curAB;
  logic [BN-1:0] expPos;

  quad_decoder #(.N(BN), .FILT(BFILT)) dut (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_quad_a (quadA),
    .i_quad_b (quadB),
    .i_clr    (clr),
    .i_err_clr(errClr),
    .i_index  (index),
    .o_pos    (pos),
    .o_dir    (dir),
    .o_step   (step),
    .o_err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycleCount);
    end
  endtask

  function automatic logic [1:0] fwdNext(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] revNext(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Monitor: retire overdue expectations, then compare each step pulse with the queue head.
  always @(negedge clk) begin
    while (sbQ.size() > 0 && sbQ[0].cyc < cycleCount) begin
      checks++;
      errors++;
      $display("[TB] FAIL missing_step: got no step, expected pos 0x%0h at cycle %0d", sbQ[0].pos, sbQ[0].cyc);
      void'(sbQ.pop_front());
    end
    if (!reset && step) begin
      stepsSeen++;
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_step: got step with pos 0x%0h, expected no step (cycle %0d)", pos, cycleCount);
      end else begin
        sbEntry_t e;
        e = sbQ.pop_front();
        checkOutput("step_pos", 32'(pos), 32'(e.pos));
        checkOutput("step_dir", 32'(dir), 32'(e.dir));
        checkOutput("step_cycle", 32'(cycleCount), 32'(e.cyc));
      end
    end
  end

  task automatic resetDut(input logic a, input logic b);
    @(negedge clk);
    reset  = 1'b1;
    quadA  = a;
    quadB  = b;
    clr    = 1'b0;
    errClr = 1'b0;
    index  = 1'b0;
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    curAB  = {a, b};
    expPos = '0;
    repeat (20) @(negedge clk);
  endtask

  // Issue one quadrature edge, optionally with clr on the cycle its step lands.
  task automatic applyStimulus(input bit fwd, input bit withClr);
    sbEntry_t   e;
    logic [1:0] nextAB;
    @(negedge clk);
    nextAB = fwd ? fwdNext(curAB) : revNext(curAB);
    if (withClr) expPos = '0;
    else if (fwd) expPos = expPos + BN'(1);
    else expPos = expPos - BN'(1);
    e.pos = expPos;
    e.dir = fwd;
    e.cyc = cycleCount + BFILT + 3;
    sbQ.push_back(e);
    quadA = nextAB[1];
    quadB = nextAB[0];
    curAB = nextAB;
    if (withClr) begin
      repeat (BFILT + 2) @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      repeat (HOLD - BFILT - 3) @(negedge clk);
    end else begin
      repeat (HOLD - 1) @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks     = 0;
    errors     = 0;
    cycleCount = 0;
    stepsSeen  = 0;
    reset      = 1'b1;
    quadA      = 1'b0;
    quadB      = 1'b0;
    clr        = 1'b0;
    errClr     = 1'b0;
    index      = 1'b0;
    curAB      = 2'b00;
    expPos     = '0;

    // Test 1: reset values, then release with A=B=1 and hold 20 cycles.
    @(negedge clk);
    quadA = 1'b1;
    quadB = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_pos", 32'(pos), 32'h0);
    checkOutput("reset_dir", 32'(dir), 32'h0);
    checkOutput("reset_step", 32'(step), 32'h0);
    checkOutput("reset_err", 32'(err), 32'h0);
    stepsBefore = stepsSeen;
    reset = 1'b0;
    curAB = 2'b11;
    repeat (20) @(negedge clk);
    checkOutput("warmup_pos", 32'(pos), 32'h0);
    checkOutput("warmup_err", 32'(err), 32'h0);
    checkOutput("warmup_steps", 32'(stepsSeen - stepsBefore), 32'h0);

    // Test 2: one full forward cycle gives four steps.
    resetDut(1'b0, 1'b0);
    stepsBefore = stepsSeen;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("fwd_steps", 32'(stepsSeen - stepsBefore), 32'd4);
    checkOutput("fwd_pos", 32'(pos), 32'd4);
    checkOutput("fwd_dir", 32'(dir), 32'd1);

    // Test 3: reverse from zero wraps to all ones; forward across the sign boundary.
    resetDut(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("rev_wrap_pos", 32'(pos), 32'hFF);
    checkOutput("rev_wrap_dir", 32'(dir), 32'h0);
    for (int i = 0; i < 128; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("pos_max", 32'(pos), 32'h7F);
    applyStimulus(1'b1, 1'b0);
    checkOutput("pos_signwrap", 32'(pos), 32'h80);

    // Test 4: short glitch is rejected; simultaneous change sets err; err_clr behaviour.
    resetDut(1'b0, 1'b0);
    stepsBefore = stepsSeen;
    @(negedge clk);
    quadA = 1'b1;
    @(negedge clk);
    quadA = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("glitch_steps", 32'(stepsSeen - stepsBefore), 32'h0);
    checkOutput("glitch_pos", 32'(pos), 32'h0);
    quadA = 1'b1;
    quadB = 1'b1;
    curAB = 2'b11;
    repeat (10) @(negedge clk);
    checkOutput("illegal_err", 32'(err), 32'h1);
    checkOutput("illegal_pos", 32'(pos), 32'h0);
    errClr = 1'b1;
    @(negedge clk);
    errClr = 1'b0;
    checkOutput("errclr_err", 32'(err), 32'h0);
    quadA = 1'b0;
    quadB = 1'b0;
    curAB = 2'b00;
    repeat (BFILT + 2) @(negedge clk);
    errClr = 1'b1;
    @(negedge clk);
    errClr = 1'b0;
    checkOutput("illegal_beats_errclr", 32'(err), 32'h1);
    errClr = 1'b1;
    @(negedge clk);
    errClr = 1'b0;
    checkOutput("errclr_again", 32'(err), 32'h0);
    checkOutput("illegal_steps", 32'(stepsSeen - stepsBefore), 32'h0);

    // Test 5: clr coincident with a step zeroes pos; counting resumes from zero.
    resetDut(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("clr_pos", 32'(pos), 32'h0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("clr_resume_pos", 32'(pos), 32'h1);

    // Test 6: index rising while filtered A/B is 11 with pos=37.
    resetDut(1'b1, 1'b0);
    for (int i = 0; i < 37; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("index_pre_pos", 32'(pos), 32'd37);
    checkOutput("index_pre_ab", 32'(curAB), 32'h3);
    @(negedge clk);
    index = 1'b1;
    repeat (BFILT + 2) @(negedge clk);
    checkOutput("index_early_pos", 32'(pos), 32'd37);
    @(negedge clk);
`ifdef QUAD_INDEX_EN
    checkOutput("index_load_pos", 32'(pos), 32'd0);
`else
    checkOutput("index_ignored_pos", 32'(pos), 32'd37);
`endif
    repeat (5) @(negedge clk);

    checkOutput("scoreboard_empty", 32'(sbQ.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
